lsu_mem_ctrl: RTL and testbench

Sequencer for the MEM stage of the basic pipeline processor. It takes the effective address produced by the load/store unit (rs1 + imm) and the decoded `aluSelect` code, then runs a request/acknowledge transaction on the data-memory port. It also generates byte enables and store-lane replication, and formats load data with sign or zero extension. It stalls the pipeline until the access completes.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/lsu_lane_format.sv | 48 ++++
 rtl/lsu_mem_ctrl.sv | 158 +++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared op codes, FSM state and access-size types for the MEM-stage load/store sequencer.
package lsu_pkg;

    localparam logic [5:0] OP_LB  = 6'b001011;
    localparam logic [5:0] OP_LH  = 6'b001100;
    localparam logic [5:0] OP_LW  = 6'b001101;
    localparam logic [5:0] OP_LBU = 6'b001110;
    localparam logic [5:0] OP_LHU = 6'b001111;
    localparam logic [5:0] OP_SB  = 6'b010000;
    localparam logic [5:0] OP_SH  = 6'b010001;
    localparam logic [5:0] OP_SW  = 6'b010010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    function automatic logic is_ls(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_SW);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op >= OP_LB) && (op <= OP_LHU);
    endfunction

    function automatic size_e op_size(input logic [5:0] op);
        size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            default:              sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/lsu_lane_format.sv
// Combinational lane logic: byte enables, store-lane replication and load extract/extend.
module lsu_lane_format
    import lsu_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_fmt
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        be       = 4'b1111;
        wdata    = store_data;
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (op_size(op))
            SZ_BYTE: begin
                be    = 4'b0001 << offset;
                wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                be    = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{store_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = store_data;
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_LB:   load_fmt = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  load_fmt = {24'h000000, byte_sel};
            OP_LH:   load_fmt = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  load_fmt = {16'h0000, half_sel};
            default: load_fmt = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store sequencer: req/ack data-memory transaction with timeout and pipeline stall.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [5:0]  aluSelect,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        bus_err,
    output logic        misalign,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] sd_q, sd_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;
    logic        accept;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
`ifdef LSU_MISALIGN_CHECK_EN
    logic        mis_q, mis_d;
    logic        misaligned;
    size_e       acc_size;
`endif

    lsu_lane_format u_lane (
        .op         (op_q),
        .offset     (addr_q[1:0]),
        .store_data (sd_q),
        .rdata      (dmem_rdata),
        .be         (lane_be),
        .wdata      (lane_wdata),
        .load_fmt   (lane_load)
    );

    assign accept = (state_q == ST_IDLE) && op_valid && is_ls(aluSelect);

`ifdef LSU_MISALIGN_CHECK_EN
    always_comb begin
        acc_size   = op_size(aluSelect);
        misaligned = ((acc_size == SZ_HALF) && address[0]) ||
                     ((acc_size == SZ_WORD) && (address[1:0] != 2'b00));
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            addr_q      <= '0;
            sd_q        <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            sd_q        <= sd_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
`ifdef LSU_MISALIGN_CHECK_EN
            mis_q       <= mis_d;
`endif
        end
    end

    // Ack is tested before the timeout compare so an ack on the final count still completes normally.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        sd_d        = sd_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        load_data_d = load_data_q;
`ifdef LSU_MISALIGN_CHECK_EN
        mis_d       = mis_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d        = aluSelect;
                    addr_d      = address;
                    sd_d        = store_data;
                    cnt_d       = '0;
                    err_d       = 1'b0;
                    load_data_d = '0;
                    state_d     = ST_REQ;
`ifdef LSU_MISALIGN_CHECK_EN
                    mis_d       = misaligned;
                    if (misaligned) begin
                        state_d = ST_DONE;
                    end
`endif
                end
            end
            ST_REQ: begin
                if (dmem_ack) begin
                    load_data_d = is_load(op_q) ? lane_load : 32'h0;
                    state_d     = ST_DONE;
                end else if (cnt_q == LAST_COUNT) begin
                    err_d       = 1'b1;
                    load_data_d = '0;
                    state_d     = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dmem_req   = (state_q == ST_REQ);
        dmem_we    = dmem_req && !is_load(op_q);
        dmem_addr  = {addr_q[31:2], 2'b00};
        dmem_be    = dmem_req ? lane_be : 4'b0000;
        dmem_wdata = dmem_req ? lane_wdata : 32'h0;
        stall      = accept || dmem_req;
        load_data  = load_data_q;
        bus_err    = (state_q == ST_DONE) && err_q;
`ifdef LSU_MISALIGN_CHECK_EN
        misalign   = (state_q == ST_DONE) && mis_q;
        load_valid = (state_q == ST_DONE) && is_load(op_q) && !err_q && !mis_q;
`else
        misalign   = 1'b0;
        load_valid = (state_q == ST_DONE) && is_load(op_q) && !err_q;
`endif
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed self-checking bench for lsu_mem_ctrl with TIMEOUT_CYCLES=4.
// Misalign expectations follow LSU_MISALIGN_CHECK_EN.
module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst_n;
    logic        op_valid;
    logic [5:0]  aluSelect;
    logic [31:0] address;
    logic [31:0] store_data;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
    logic        misalign;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    int assertions = 0;
    int failures   = 0;

    int          obs_stall;
    int          obs_req;
    int          obs_lv_cnt;
    int          obs_berr_cnt;
    logic        done_seen;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic        obs_we;
    logic [31:0] obs_wdata;
    logic [31:0] obs_ld;
    logic        obs_lv;
    logic        obs_berr;
    logic        obs_mis;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op_valid   (op_valid),
        .aluSelect  (aluSelect),
        .address    (address),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .bus_err    (bus_err),
        .misalign   (misalign),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Runs one op from the accept cycle through DONE; ack arrives in REQ cycle number ack_after (-1 = never).
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sd,
                                 input int ack_after, input logic [31:0] rdata);
        obs_stall = 0; obs_req = 0; obs_lv_cnt = 0; obs_berr_cnt = 0; done_seen = 1'b0;
        obs_addr = '0; obs_be = '0; obs_we = 1'b0; obs_wdata = '0;
        obs_ld = '0; obs_lv = 1'b0; obs_berr = 1'b0; obs_mis = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; aluSelect = op; address = addr; store_data = sd;
        dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (stall) obs_stall++;
            if (load_valid) obs_lv_cnt++;
            if (bus_err) obs_berr_cnt++;
            if (dmem_req) begin
                if (obs_req == 0) begin
                    obs_addr = dmem_addr; obs_be = dmem_be; obs_we = dmem_we; obs_wdata = dmem_wdata;
                end
                if (obs_req == ack_after) begin
                    dmem_ack = 1'b1; dmem_rdata = rdata;
                end
                obs_req++;
            end
            if (!stall && cyc > 0) begin
                obs_ld = load_data; obs_lv = load_valid; obs_berr = bus_err; obs_mis = misalign;
                done_seen = 1'b1;
                break;
            end
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = 32'h5A5A_5A5A;
            #1;
        end
        if (!done_seen) checkOutput("done_reached", 32'(done_seen), 32'd1);
        @(negedge clk);
        op_valid = 1'b0; aluSelect = '0;
        #1;
        if (load_valid) obs_lv_cnt++;
        if (bus_err) obs_berr_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; op_valid = 1'b0; aluSelect = '0; address = '0; store_data = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_req",   32'(dmem_req),   32'd0);
        checkOutput("rst_we",    32'(dmem_we),    32'd0);
        checkOutput("rst_be",    32'(dmem_be),    32'd0);
        checkOutput("rst_addr",  dmem_addr,       32'd0);
        checkOutput("rst_wdata", dmem_wdata,      32'd0);
        checkOutput("rst_ld",    load_data,       32'd0);
        checkOutput("rst_flags", {29'd0, load_valid, bus_err, misalign}, 32'd0);
        checkOutput("rst_stall", 32'(stall),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // SW zero-wait
        applyStimulus(6'b010010, 32'h0000_1010, 32'hDEAD_BEEF, 0, 32'h0);
        checkOutput("sw_addr",  obs_addr,         32'h0000_1010);
        checkOutput("sw_be",    32'(obs_be),      32'hF);
        checkOutput("sw_we",    32'(obs_we),      32'd1);
        checkOutput("sw_wdata", obs_wdata,        32'hDEAD_BEEF);
        checkOutput("sw_stall", 32'(obs_stall),   32'd2);
        checkOutput("sw_lv",    32'(obs_lv_cnt),  32'd0);

        // LB, ack on final count before timeout
        applyStimulus(6'b001011, 32'h0000_1013, 32'h0, 3, 32'h80FF_0000);
        checkOutput("lb_be",    32'(obs_be),      32'h8);
        checkOutput("lb_we",    32'(obs_we),      32'd0);
        checkOutput("lb_ld",    obs_ld,           32'hFFFF_FF80);
        checkOutput("lb_lv",    32'(obs_lv),      32'd1);
        checkOutput("lb_lvcnt", 32'(obs_lv_cnt),  32'd1);
        checkOutput("lb_berr",  32'(obs_berr_cnt),32'd0);
        checkOutput("lb_stall", 32'(obs_stall),   32'd5);

        applyStimulus(6'b001111, 32'h0000_1002, 32'h0, 0, 32'h8001_1234);
        checkOutput("lhu_be",   32'(obs_be),      32'hC);
        checkOutput("lhu_ld",   obs_ld,           32'h0000_8001);
        applyStimulus(6'b001100, 32'h0000_1002, 32'h0, 1, 32'h8001_1234);
        checkOutput("lh_ld",    obs_ld,           32'hFFFF_8001);
        checkOutput("lh_stall", 32'(obs_stall),   32'd3);

        applyStimulus(6'b001110, 32'h0000_1011, 32'h0, 0, 32'h1234_8856);
        checkOutput("lbu_be",   32'(obs_be),      32'h2);
        checkOutput("lbu_ld",   obs_ld,           32'h0000_0088);
        applyStimulus(6'b001101, 32'h0000_1000, 32'h0, 0, 32'hCAFE_F00D);
        checkOutput("lw_ld",    obs_ld,           32'hCAFE_F00D);

        applyStimulus(6'b010000, 32'h0000_1001, 32'h1234_56A5, 0, 32'h0);
        checkOutput("sb_be",    32'(obs_be),      32'h2);
        checkOutput("sb_wdata", obs_wdata,        32'hA5A5_A5A5);
        applyStimulus(6'b010001, 32'h0000_1002, 32'h7777_BEEF, 0, 32'h0);
        checkOutput("sh_be",    32'(obs_be),      32'hC);
        checkOutput("sh_wdata", obs_wdata,        32'hBEEF_BEEF);
        checkOutput("sh_addr",  obs_addr,         32'h0000_1000);

        // Timeout: no ack
        applyStimulus(6'b001101, 32'h0000_2000, 32'h0, -1, 32'h0);
        checkOutput("to_req",   32'(obs_req),     32'd4);
        checkOutput("to_stall", 32'(obs_stall),   32'd5);
        checkOutput("to_berr",  32'(obs_berr),    32'd1);
        checkOutput("to_bcnt",  32'(obs_berr_cnt),32'd1);
        checkOutput("to_ld",    obs_ld,           32'd0);
        checkOutput("to_lv",    32'(obs_lv_cnt),  32'd0);

        // Non-load/store code is ignored
        @(negedge clk);
        op_valid = 1'b1; aluSelect = 6'b011000; address = 32'h0000_3000;
        #1;
        checkOutput("nls_stall", 32'(stall),      32'd0);
        checkOutput("nls_req0",  32'(dmem_req),   32'd0);
        @(negedge clk);
        #1;
        checkOutput("nls_req1",  32'(dmem_req),   32'd0);

        // Reset in the middle of REQ
        @(negedge clk);
        aluSelect = 6'b001101; address = 32'h0000_4000;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        checkOutput("mid_req",   32'(dmem_req),   32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_drop",  32'(dmem_req),   32'd0);
        checkOutput("rst_stall", 32'(stall),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(6'b001101, 32'h0000_1004, 32'h0, 0, 32'h0BAD_F00D);
        checkOutput("post_stall", 32'(obs_stall), 32'd2);
        checkOutput("post_ld",    obs_ld,         32'h0BAD_F00D);

        // Misaligned word load
        applyStimulus(6'b001101, 32'h0000_1001, 32'h0, 0, 32'h1111_2222);
`ifdef LSU_MISALIGN_CHECK_EN
        checkOutput("mis_pulse", 32'(obs_mis),    32'd1);
        checkOutput("mis_req",   32'(obs_req),    32'd0);
        checkOutput("mis_stall", 32'(obs_stall),  32'd1);
        checkOutput("mis_ld",    obs_ld,          32'd0);
        checkOutput("mis_lv",    32'(obs_lv_cnt), 32'd0);
`else
        checkOutput("mis_pulse", 32'(obs_mis),    32'd0);
        checkOutput("mis_be",    32'(obs_be),     32'hF);
        checkOutput("mis_addr",  obs_addr,        32'h0000_1000);
        checkOutput("mis_stall", 32'(obs_stall),  32'd2);
        checkOutput("mis_ld",    obs_ld,          32'h1111_2222);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
